// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match sequencer and its datapath neighbours.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SERVE_WAIT = 3'd1,
        ST_RALLY      = 3'd2,
        ST_POINT      = 3'd3,
        ST_GAME_OVER  = 3'd4
    } game_state_e;

    localparam logic [1:0] WINNER_NONE  = 2'b00;
    localparam logic [1:0] WINNER_LEFT  = 2'b01;
    localparam logic [1:0] WINNER_RIGHT = 2'b10;

    localparam logic SERVE_LEFT  = 1'b0;
    localparam logic SERVE_RIGHT = 1'b1;

endpackage

// File: rtl/game_round_controller_if.sv
// Event inputs and game-flow outputs between the round controller and the rest of the pong design.
interface game_round_controller_if;

    logic       frame_tick;
    logic       start_btn;
    logic       pause_btn;
    logic       miss_left;
    logic       miss_right;
    logic       game_start;
    logic       serve;
    logic       serve_dir;
    logic       ball_enable;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic [1:0] winner;
    logic [2:0] state_o;

    modport master (
        output frame_tick, start_btn, pause_btn, miss_left, miss_right,
        input  game_start, serve, serve_dir, ball_enable,
               score_left, score_right, winner, state_o
    );

    modport slave (
        input  frame_tick, start_btn, pause_btn, miss_left, miss_right,
        output game_start, serve, serve_dir, ball_enable,
               score_left, score_right, winner, state_o
    );

endinterface

// File: rtl/game_round_controller_frame_timer.sv
// Loadable 8-bit down-counter clocked by frame ticks; done while the count sits at zero.
module frame_timer (
    input  logic       clk_25MHz,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       load,
    input  logic       hold,
    input  logic [7:0] value,
    output logic       done
);

    logic [7:0] count;

    // Load wins over a coincident tick, so the first tick after entry is never lost or doubled.
    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            count <= 8'd0;
        end else if (load) begin
            count <= value;
        end else if (frame_tick && !hold && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

    assign done = (count == 8'd0);

endmodule

// File: rtl/game_round_controller.sv
// Match-level sequencer for two-player pong: serve delay, rally, point award, game over, scores.
module game_round_controller
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int OVER_FRAMES  = 180
) (
    input  logic                    clk_25MHz,
    input  logic                    reset_n,
    game_round_controller_if.slave  bus
);

    localparam logic [3:0] WIN_S      = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES);
    localparam logic [7:0] OVER_LOAD  = 8'(OVER_FRAMES);

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= WIN_S) ? v : v + 4'd1;
    endfunction

    game_state_e state, next_state;

    logic       game_start_q, game_start_d;
    logic       serve_q, serve_d;
    logic       serve_dir_q, serve_dir_d;
    logic       ball_enable_q, ball_enable_d;
    logic [3:0] score_left_q, score_left_d;
    logic [3:0] score_right_q, score_right_d;
    logic [1:0] winner_q, winner_d;
    logic       paused_q, paused_d;
    logic       point_right_q, point_right_d;

    logic       timer_load;
    logic [7:0] timer_value;
    logic       timer_done;
    logic [3:0] pend_score;
    logic [3:0] new_score;
    logic       point_won;
    logic       state_change;
    logic       single_miss;

    frame_timer u_frame_timer (
        .clk_25MHz  (clk_25MHz),
        .reset_n    (reset_n),
        .frame_tick (bus.frame_tick),
        .load       (timer_load),
        .hold       (paused_q),
        .value      (timer_value),
        .done       (timer_done)
    );

    assign pend_score  = point_right_q ? score_right_q : score_left_q;
    assign new_score   = sat_inc(pend_score);
    assign point_won   = (new_score == WIN_S);
    assign single_miss = bus.miss_left ^ bus.miss_right;

    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (bus.start_btn) next_state = ST_SERVE_WAIT;
            end
            ST_SERVE_WAIT: begin
                if (timer_done && !paused_q) next_state = ST_RALLY;
            end
            ST_RALLY: begin
                if (!paused_q) begin
                    if (bus.miss_left && bus.miss_right) next_state = ST_SERVE_WAIT;
                    else if (single_miss)                next_state = ST_POINT;
                end
            end
            ST_POINT: begin
                next_state = point_won ? ST_GAME_OVER : ST_SERVE_WAIT;
            end
            ST_GAME_OVER: begin
                if (bus.start_btn)   next_state = ST_SERVE_WAIT;
                else if (timer_done) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        game_start_d  = 1'b0;
        serve_d       = 1'b0;
        serve_dir_d   = serve_dir_q;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        winner_d      = winner_q;
        point_right_d = point_right_q;
        state_change  = (next_state != state);

        // Any state change drops the pause so a new phase always starts running.
        paused_d = paused_q;
        if (state_change) begin
            paused_d = 1'b0;
        end else if (bus.pause_btn && (state == ST_SERVE_WAIT || state == ST_RALLY)) begin
            paused_d = ~paused_q;
        end

        case (state)
            ST_IDLE, ST_GAME_OVER: begin
                if (bus.start_btn) begin
                    game_start_d  = 1'b1;
                    score_left_d  = 4'd0;
                    score_right_d = 4'd0;
                    winner_d      = WINNER_NONE;
                    serve_dir_d   = SERVE_RIGHT;
                end
            end
            ST_SERVE_WAIT: begin
                if (next_state == ST_RALLY) serve_d = 1'b1;
            end
            ST_RALLY: begin
                if (!paused_q && single_miss) begin
                    point_right_d = bus.miss_left;
                    serve_dir_d   = bus.miss_left ? SERVE_LEFT : SERVE_RIGHT;
                end
            end
            ST_POINT: begin
                if (point_right_q) score_right_d = new_score;
                else               score_left_d  = new_score;
                if (point_won) winner_d = point_right_q ? WINNER_RIGHT : WINNER_LEFT;
            end
            default: ;
        endcase

        ball_enable_d = (next_state == ST_RALLY) && !paused_d;
        timer_load    = state_change &&
                        (next_state == ST_SERVE_WAIT || next_state == ST_GAME_OVER);
        timer_value   = (next_state == ST_GAME_OVER) ? OVER_LOAD : SERVE_LOAD;
    end

    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            game_start_q  <= 1'b0;
            serve_q       <= 1'b0;
            serve_dir_q   <= SERVE_RIGHT;
            ball_enable_q <= 1'b0;
            score_left_q  <= 4'd0;
            score_right_q <= 4'd0;
            winner_q      <= WINNER_NONE;
            paused_q      <= 1'b0;
            point_right_q <= 1'b0;
        end else begin
            game_start_q  <= game_start_d;
            serve_q       <= serve_d;
            serve_dir_q   <= serve_dir_d;
            ball_enable_q <= ball_enable_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            winner_q      <= winner_d;
            paused_q      <= paused_d;
            point_right_q <= point_right_d;
        end
    end

    assign bus.game_start  = game_start_q;
    assign bus.serve       = serve_q;
    assign bus.serve_dir   = serve_dir_q;
    assign bus.ball_enable = ball_enable_q;
    assign bus.score_left  = score_left_q;
    assign bus.score_right = score_right_q;
    assign bus.winner      = winner_q;
    assign bus.state_o     = state;

endmodule

// File: doc/game_round_controller.md
# game_round_controller

Match-level sequencer for the two-player pong design. It runs the game flow: start, serve delay, rally, point award, game over. It holds both players' scores and drives the start, serve and enable strobes consumed by the ball mover and the per-player score calculators. It sits between the debounced button inputs and the frame-tick generator on one side and the ball/score datapath on the other.

## Interface
- WIN_SCORE, 7: points needed to win; legal range 1..15.
- SERVE_FRAMES, 60: frame ticks between entering SERVE_WAIT and the serve strobe; legal range 1..255.
- OVER_FRAMES, 180: frame ticks GAME_OVER is held before returning to IDLE; legal range 1..255.
- clk_25MHz  input  1  pixel clock; the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- frame_tick  input  1  one-cycle pulse per video frame.
- start_btn  input  1  one-cycle debounced press pulse.
- pause_btn  input  1  one-cycle debounced press pulse.
- miss_left  input  1  one-cycle pulse: ball passed the left paddle.
- miss_right  input  1  one-cycle pulse: ball passed the right paddle.
- game_start  output  1  one-cycle pulse; clears the downstream score calculators.
- serve  output  1  one-cycle pulse; ball launches toward serve_dir.
- serve_dir  output  1  0 = toward left player, 1 = toward right player.
- ball_enable  output  1  high while ball motion is permitted.
- score_left  output  4  left player's score.
- score_right  output  4  right player's score.
- winner  output  2  00 none, 01 left, 10 right.
- state_o  output  3  current state encoding, for on-screen display.

## Operation
- States: IDLE, SERVE_WAIT, RALLY, POINT, GAME_OVER.
- IDLE
  - ball_enable = 0; scores are held for display.
  - start_btn: pulse game_start, clear both scores, set winner = 00, set serve_dir = 1, go to SERVE_WAIT.
- SERVE_WAIT
  - The frame counter loads SERVE_FRAMES on entry and decrements on each frame_tick.
  - When it reaches 0: pulse serve and go to RALLY.
- RALLY
  - ball_enable = 1.
  - miss_left: right player gains a point; serve_dir becomes 0 (serve goes to the loser). Go to POINT.
  - miss_right: left player gains a point; serve_dir becomes 1. Go to POINT.
  - miss_left and miss_right in the same cycle: no point, serve_dir unchanged, go directly to SERVE_WAIT.
- POINT (exactly one cycle)
  - Increment the pending player's score.
  - If the new value equals WIN_SCORE: set winner and go to GAME_OVER. Otherwise go to SERVE_WAIT.
  - Scores never exceed WIN_SCORE; no wrap-around.
- GAME_OVER
  - ball_enable = 0.
  - The counter loads OVER_FRAMES and decrements on frame_tick; at 0, go to IDLE with scores and winner held.
  - start_btn in GAME_OVER restarts immediately, with the same action as from IDLE.
- Pause
  - pause_btn in SERVE_WAIT or RALLY toggles the paused flag.
  - While paused: ball_enable = 0, frame_tick is ignored, miss pulses are ignored.
  - pause_btn in any other state is ignored. The paused flag clears on every state change.
- start_btn in SERVE_WAIT, RALLY or POINT is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE
  - scores 0
  - winner 00
  - serve_dir 1
  - ball_enable 0
  - game_start 0
  - serve 0
  - paused 0
- Input-to-output latency:
  - start_btn to game_start: one cycle. game_start is high in the first SERVE_WAIT cycle.
  - The serve pulse is asserted in the cycle after the counter reaches 0. ball_enable rises in the same cycle as serve.
  - A miss pulse to ball_enable low: one cycle.
  - The score update is visible two cycles after the miss pulse (through POINT).
- frame_tick coincident with state entry: the counter loads and does not decrement in that cycle.
- Reset mid-operation: all state returns to the reset values immediately; no strobe is emitted.

## Structure
- Shared package pong_pkg holds:
  - game_state_e enum (3-bit)
  - WINNER_NONE, WINNER_LEFT, WINNER_RIGHT constants
  - SERVE_LEFT and SERVE_RIGHT constants
- Sub-module frame_timer is a loadable 8-bit down-counter on frame_tick, with inputs load, value and hold and output done. One instance is shared by SERVE_WAIT and GAME_OVER.

## Test plan
- Reset, start_btn, then 60 frame ticks: game_start pulses once, then serve pulses once with serve_dir = 1 and ball_enable = 1.
- In RALLY, miss_right: ball_enable drops the next cycle, score_left = 1, serve_dir = 1, next serve after 60 ticks.
- Left wins 7-0 (WIN_SCORE = 7): winner = 01, ball_enable = 0. After 180 ticks state returns to IDLE with score_left = 7 held.
- miss_left and miss_right in the same cycle: both scores unchanged, back to SERVE_WAIT, serve_dir unchanged.
- pause_btn in RALLY, then 100 frame ticks and a miss_left pulse: nothing changes. A second pause_btn restores ball_enable = 1.
- reset_n asserted mid-RALLY at a score of 3-2: all outputs return to reset values asynchronously.
